// File: rtl/uvma_mstream_arb.sv
// Matrix-granular round-robin arbiter: N_REQ mstream sources share one registered output port.
// A grant is held from the first beat to the eom beat. A stall watchdog drops a source that stays idle too long mid-matrix.
module uvma_mstream_arb #(
  parameter int N_REQ          = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                          sys_clk,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req_vld,
  output logic [N_REQ-1:0]              req_rdy,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [N_REQ-1:0]              req_eom,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_eom,
  output logic [$clog2(N_REQ)-1:0]      out_src,
  output logic                          busy,
  output logic                          err_timeout,
  output logic [$clog2(N_REQ)-1:0]      err_src,
  input  logic                          err_clr,
  output logic [15:0]                   mtx_count
);

  localparam int SW = $clog2(N_REQ);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] STALL_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [SW-1:0]         grant_q, grant_d;
  logic [SW-1:0]         last_grant_q, last_grant_d;
  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_eom_q, out_eom_d;
  logic [SW-1:0]         out_src_q, out_src_d;
  logic                  err_timeout_q, err_timeout_d;
  logic [SW-1:0]         err_src_q, err_src_d;
  logic [15:0]           mtx_count_q, mtx_count_d;
  logic [CW-1:0]         stall_cnt_q, stall_cnt_d;

  logic                  sel_vld_s;
  logic                  sel_eom_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic                  rr_found_s;
  logic [SW-1:0]         rr_pick_s;
  int                    rr_best_s;
  logic                  out_free_s;
  logic                  accept_s;
  logic                  timeout_s;

  // Select the granted source's valid, eom and data.
  always_comb begin
    sel_vld_s  = 1'b0;
    sel_eom_s  = 1'b0;
    sel_data_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_vld_s  = sel_vld_s | ((grant_q == SW'(i)) & req_vld[i]);
      sel_eom_s  = sel_eom_s | ((grant_q == SW'(i)) & req_eom[i]);
      sel_data_s = sel_data_s | ({DATA_WIDTH{grant_q == SW'(i)}} & req_data[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Round-robin pick: smallest distance past last_grant among the requesting sources.
  always_comb begin
    rr_found_s = |req_vld;
    rr_pick_s  = '0;
    rr_best_s  = N_REQ;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_vld[i] && (((i + N_REQ - 1 - int'(last_grant_q)) % N_REQ) < rr_best_s)) begin
        rr_best_s = (i + N_REQ - 1 - int'(last_grant_q)) % N_REQ;
        rr_pick_s = SW'(i);
      end else begin
        rr_best_s = rr_best_s;
      end
    end
  end

  assign out_free_s = !out_vld_q || out_rdy;
  assign accept_s   = (state_q == ST_LOCKED) && sel_vld_s && out_free_s;
  assign timeout_s  = WDOG_EN && (state_q == ST_LOCKED) && !sel_vld_s && (stall_cnt_q == STALL_LAST);

  // Ready is given only to the locked source, and only when the output register can take a beat.
  always_comb begin
    req_rdy = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_rdy[i] = (state_q == ST_LOCKED) && (grant_q == SW'(i)) && out_free_s;
    end
  end

  // Next-state: arbitration FSM, watchdog, output register, error flag and matrix counter.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    out_vld_d     = out_vld_q;
    out_data_d    = out_data_q;
    out_eom_d     = out_eom_q;
    out_src_d     = out_src_q;
    err_timeout_d = err_timeout_q;
    err_src_d     = err_src_q;
    mtx_count_d   = mtx_count_q;
    stall_cnt_d   = stall_cnt_q;

    case (state_q)
      ST_IDLE: begin
        stall_cnt_d = '0;
        if (rr_found_s) begin
          state_d = ST_LOCKED;
          grant_d = rr_pick_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (accept_s) begin
          stall_cnt_d = '0;
          if (sel_eom_s) begin
            state_d      = ST_IDLE;
            last_grant_d = grant_q;
            mtx_count_d  = mtx_count_q + 16'd1;
          end else begin
            state_d = ST_LOCKED;
          end
        end else if (timeout_s) begin
          state_d      = ST_IDLE;
          last_grant_d = grant_q;
          stall_cnt_d  = '0;
        end else if (sel_vld_s) begin
          stall_cnt_d = '0;
        end else begin
          stall_cnt_d = stall_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept_s) begin
      out_vld_d  = 1'b1;
      out_data_d = sel_data_s;
      out_eom_d  = sel_eom_s;
      out_src_d  = grant_q;
    end else if (out_vld_q && out_rdy) begin
      out_vld_d = 1'b0;
    end else begin
      out_vld_d = out_vld_q;
    end

    // A timeout in the same cycle as err_clr keeps the flag set.
    if (timeout_s) begin
      err_timeout_d = 1'b1;
      err_src_d     = grant_q;
    end else if (err_clr) begin
      err_timeout_d = 1'b0;
    end else begin
      err_timeout_d = err_timeout_q;
    end
  end

  // State and output registers.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      last_grant_q  <= SW'(N_REQ - 1);
      out_vld_q     <= 1'b0;
      out_data_q    <= '0;
      out_eom_q     <= 1'b0;
      out_src_q     <= '0;
      err_timeout_q <= 1'b0;
      err_src_q     <= '0;
      mtx_count_q   <= 16'd0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      out_vld_q     <= out_vld_d;
      out_data_q    <= out_data_d;
      out_eom_q     <= out_eom_d;
      out_src_q     <= out_src_d;
      err_timeout_q <= err_timeout_d;
      err_src_q     <= err_src_d;
      mtx_count_q   <= mtx_count_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign out_vld     = out_vld_q;
  assign out_data    = out_data_q;
  assign out_eom     = out_eom_q;
  assign out_src     = out_src_q;
  assign busy        = (state_q == ST_LOCKED);
  assign err_timeout = err_timeout_q;
  assign err_src     = err_src_q;
  assign mtx_count   = mtx_count_q;

endmodule

// File: doc/uvma_mstream_arb.md
Name: uvma_mstream_arb

Overview:
- Matrix-granular round-robin arbiter that shares one Matrix Stream (mstream) output port between N_REQ mstream sources.
- A grant is locked from a source's first accepted beat until its end-of-matrix (eom) beat, so matrices are never interleaved.
- Sits between the DUT-side producers and the single mstream sink port monitored by the mstream agent and interface checker.
- A registered output stage, a stall watchdog and status counters are included.

Parameters:
- N_REQ, 4: number of requesting sources (2..8).
- DATA_WIDTH, 32: mstream beat data width.
- TIMEOUT_CYCLES, 256: maximum consecutive cycles a locked source may hold req_vld low mid-matrix; 0 disables the watchdog.

Ports:
- sys_clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_vld  in  N_REQ  per-source beat valid.
- req_rdy  out  N_REQ  per-source beat ready.
- req_data  in  N_REQ*DATA_WIDTH  per-source data; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_eom  in  N_REQ  per-source end-of-matrix marker, qualified by vld.
- out_vld  out  1  output beat valid.
- out_rdy  in  1  output beat ready.
- out_data  out  DATA_WIDTH  output data.
- out_eom  out  1  output end-of-matrix.
- out_src  out  $clog2(N_REQ)  index of the source that produced the output beat.
- busy  out  1  high while in LOCKED.
- err_timeout  out  1  sticky watchdog error flag.
- err_src  out  $clog2(N_REQ)  source index captured at the timeout.
- err_clr  in  1  synchronous clear of err_timeout.
- mtx_count  out  16  number of matrices completed (eom beats accepted); wraps.

Behaviour:
- Reset values:
  - out_vld, out_data, out_eom, out_src, busy, err_timeout, err_src, mtx_count and req_rdy are all 0.
  - State is IDLE and last_grant = N_REQ-1, so source 0 has priority first.
  - Reset asserted mid-matrix clears everything at once; a beat held in the output register is dropped.
- States:
  - IDLE:
    - req_rdy is all 0.
    - If any req_vld bit is set, select the first set bit searching from last_grant+1 with wrap-around, register it as grant, and go to LOCKED.
    - Arbitration latency is 1 cycle: the first beat can be accepted in the cycle after the request is seen.
  - LOCKED:
    - req_rdy[grant] = (!out_vld || out_rdy); all other req_rdy bits are 0.
    - A beat is accepted when req_vld[grant] && req_rdy[grant]. It loads out_data, out_eom and out_src on that edge, and out_vld becomes 1.
    - An accepted beat with req_eom set returns the state to IDLE, sets last_grant = grant and increments mtx_count (16-bit wrap, 0xFFFF->0x0000).
- Output register:
  - If out_vld && out_rdy and no new beat is loaded, out_vld goes to 0.
  - Load and drain in the same cycle gives full throughput of 1 beat/cycle within a matrix.
  - Output contents are held stable while out_vld && !out_rdy.
- Inter-matrix gap: exactly 1 bubble cycle (the IDLE arbitration cycle) between matrices, including back-to-back matrices from the same source.
- Watchdog (TIMEOUT_CYCLES > 0):
  - stall_cnt counts LOCKED cycles with req_vld[grant] == 0.
  - stall_cnt resets to 0 on any cycle with req_vld[grant] == 1, and on entering LOCKED.
  - Cycles where req_vld[grant] == 1 but the output back-pressures do not count.
  - When stall_cnt reaches TIMEOUT_CYCLES:
    - set err_timeout = 1 and err_src = grant, and go to IDLE;
    - last_grant = grant, so the stalled source loses priority;
    - no eom is synthesized and mtx_count is not incremented.
- err_clr:
  - err_clr = 1 clears err_timeout on the next edge.
  - If a new timeout fires in the same cycle as err_clr, the set wins and err_src is updated.
- req_eom and req_data of non-granted sources are ignored. A source that drops req_vld mid-matrix keeps the grant (subject to the watchdog).
- Simultaneous requests in IDLE are resolved strictly by the round-robin order above. No source is starved: once all others have each completed at most one matrix, the waiting source is served.

Test Plan:
- Single source 0 sends a 4-beat matrix (data 0x10..0x13, eom on 0x13) with out_rdy = 1 -> out_vld rises 2 cycles after req_vld; 4 consecutive out beats with out_src = 0; out_eom only on 0x13; mtx_count = 1; busy falls after the eom beat.
- Sources 0..3 all request 2-beat matrices continuously -> grant order 0,1,2,3,0; no interleaving within a matrix; 1 bubble between matrices; mtx_count = 5 after 5 matrices.
- out_rdy toggles 1,0,0,1 during a 3-beat matrix -> out_data held stable while stalled; req_rdy[grant] = 0 while out_vld && !out_rdy; no beat lost or duplicated.
- TIMEOUT_CYCLES = 8: source 2 sends 1 beat without eom, then drops vld -> 8 cycles later err_timeout = 1, err_src = 2, state IDLE; a pending source 3 is granted next; err_clr pulse -> err_timeout = 0.
- Reset asserted while LOCKED with out_vld = 1 -> out_vld, busy and req_rdy go to 0 immediately without waiting for a clock edge; after release, source 0 wins a simultaneous 0/1 request.
- 65536 single-beat matrices -> mtx_count wraps to 0x0000.
